// File: rtl/fp_expand_acc_if.sv
// Handshake and data bundle between an (S, E, F) producer, the expander
// and the downstream consumer of the linear value and running sum.
interface fp_expand_acc_if #(
  parameter int ACC_W = 13
);
  logic             in_valid;
  logic             in_ready;
  logic             s;
  logic [2:0]       e;
  logic [4:0]       f;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [12:0]      d_out;
  logic [ACC_W-1:0] acc;
  logic             sat;

  // Expander side
  modport slave (
    input  in_valid, s, e, f, acc_clr, out_ready,
    output in_ready, out_valid, d_out, acc, sat
  );

  // Producer / consumer side
  modport master (
    output in_valid, s, e, f, acc_clr, out_ready,
    input  in_ready, out_valid, d_out, acc, sat
  );
endinterface

// File: rtl/fp_expand_acc.sv
// Expands a sign/exponent/significand word into a 13-bit two's-complement
// value using a one-bit-per-cycle shifter, and keeps a saturating running
// sum of every expanded value.
module fp_expand_acc #(
  parameter int ACC_W = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_expand_acc_if.slave        bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_SIGN  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t state_q, state_d;

  logic [12:0]      mag_q;
  logic [2:0]       cnt_q;
  logic             sgn_q;
  logic [12:0]      d_out_q;
  logic [ACC_W-1:0] acc_q;
  logic             sat_q;

  logic             in_ready_o;
  logic             out_valid_o;
  logic [12:0]      d_sign;
  logic [ACC_W:0]   sum;
  logic             sum_ovf;

  // Negating a zero magnitude yields zero, so s=1, f=0 never produces -0.
  assign d_sign = sgn_q ? (13'd0 - mag_q) : mag_q;

  // One guard bit: overflow shows up as the top two bits disagreeing.
  assign sum     = {{(ACC_W+1-13){d_sign[12]}}, d_sign} + {acc_q[ACC_W-1], acc_q};
  assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d = (bus.e != 3'd0) ? ST_SHIFT : ST_SIGN;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == 3'd1) begin
          state_d = ST_SIGN;
        end
      end
      ST_SIGN: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: in_ready_o  = 1'b1;
      ST_HOLD: out_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Shifter datapath: capture on accept, shift in SHIFT, latch result in SIGN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q   <= 13'd0;
      cnt_q   <= 3'd0;
      sgn_q   <= 1'b0;
      d_out_q <= 13'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            mag_q <= {8'b0, bus.f};
            cnt_q <= bus.e;
            sgn_q <= bus.s;
          end
        end
        ST_SHIFT: begin
          mag_q <= mag_q << 1;
          cnt_q <= cnt_q - 3'd1;
        end
        ST_SIGN: begin
          d_out_q <= d_sign;
        end
        default: ;
      endcase
    end
  end

  // Saturating accumulator; a clear in the SIGN cycle drops that sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (bus.acc_clr) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (state_q == ST_SIGN) begin
      if (sum_ovf) begin
        acc_q <= sum[ACC_W] ? ACC_MIN : ACC_MAX;
        sat_q <= 1'b1;
      end else begin
        acc_q <= sum[ACC_W-1:0];
      end
    end
  end

  assign bus.in_ready  = in_ready_o;
  assign bus.out_valid = out_valid_o;
  assign bus.d_out     = d_out_q;
  assign bus.acc       = acc_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_fp_expand_acc.sv
// Directed bench for fp_expand_acc with hand-computed expected values.
module tb_fp_expand_acc;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  fp_expand_acc_if #(.ACC_W(13)) bus ();

  fp_expand_acc #(.ACC_W(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int seen;

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d (0x%h) expected=%0d (0x%h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and return just after the edge that accepted it.
  task automatic accept(input logic s_v, input logic [2:0] e_v, input logic [4:0] f_v);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("accept_ready", {12'd0, bus.in_ready}, 13'd1);
    bus.s        = s_v;
    bus.e        = e_v;
    bus.f        = f_v;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Count edges from accept until out_valid, bounded.
  task automatic wait_out(input string tag, input int exp_lat);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 13'(n), 13'(exp_lat));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.s         = 1'b0;
    bus.e         = 3'd0;
    bus.f         = 5'd0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("rst_d_out",     bus.d_out,            13'd0);
    chk("rst_acc",       bus.acc,              13'd0);
    chk("rst_sat",       {12'd0, bus.sat},       13'd0);
    chk("rst_out_valid", {12'd0, bus.out_valid}, 13'd0);
    chk("rst_in_ready",  {12'd0, bus.in_ready},  13'd1);
    #4 rst = 1'b0;
    tick();

    // Positive: 27 * 4 = 108
    accept(1'b0, 3'd2, 5'b11011);
    wait_out("pos_latency", 3);
    chk("pos_d_out", bus.d_out, 13'd108);
    chk("pos_acc",   bus.acc,   13'd108);
    chk("pos_sat",   {12'd0, bus.sat}, 13'd0);
    tick();
    chk("pos_back_idle_valid", {12'd0, bus.out_valid}, 13'd0);
    chk("pos_back_idle_ready", {12'd0, bus.in_ready},  13'd1);

    // Negative: -(26 * 16) = -416, acc = 108 - 416 = -308
    accept(1'b1, 3'd4, 5'b11010);
    wait_out("neg_latency", 5);
    chk("neg_d_out", bus.d_out, 13'(-416));
    chk("neg_acc",   bus.acc,   13'(-308));
    tick();

    // Negative zero collapses to 0, acc unchanged
    accept(1'b1, 3'd5, 5'd0);
    wait_out("zero_latency", 6);
    chk("zero_d_out", bus.d_out, 13'd0);
    chk("zero_acc",   bus.acc,   13'(-308));
    tick();

    // Clear while idle
    bus.acc_clr = 1'b1;
    tick();
    bus.acc_clr = 1'b0;
    chk("clr_acc", bus.acc, 13'd0);
    chk("clr_sat", {12'd0, bus.sat}, 13'd0);

    // Saturation: 3968 + 3968 exceeds 4095
    accept(1'b0, 3'd7, 5'd31);
    wait_out("sat1_latency", 8);
    chk("sat1_d_out", bus.d_out, 13'd3968);
    chk("sat1_acc",   bus.acc,   13'd3968);
    chk("sat1_sat",   {12'd0, bus.sat}, 13'd0);
    tick();
    accept(1'b0, 3'd7, 5'd31);
    wait_out("sat2_latency", 8);
    chk("sat2_d_out", bus.d_out, 13'd3968);
    chk("sat2_acc",   bus.acc,   13'd4095);
    chk("sat2_sat",   {12'd0, bus.sat}, 13'd1);
    tick();
    bus.acc_clr = 1'b1;
    tick();
    bus.acc_clr = 1'b0;
    chk("sat_clr_acc", bus.acc, 13'd0);
    chk("sat_clr_sat", {12'd0, bus.sat}, 13'd0);

    // Backpressure: 3 * 2 = 6 held while a new word waits
    bus.out_ready = 1'b0;
    accept(1'b0, 3'd1, 5'd3);
    wait_out("bp_latency", 2);
    chk("bp_d_out", bus.d_out, 13'd6);
    bus.s        = 1'b1;
    bus.e        = 3'd0;
    bus.f        = 5'd5;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_d_out",     bus.d_out,                13'd6);
      chk("bp_hold_in_ready",  {12'd0, bus.in_ready},  13'd0);
      chk("bp_hold_out_valid", {12'd0, bus.out_valid}, 13'd1);
      chk("bp_hold_acc",       bus.acc,                  13'd6);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", {12'd0, bus.out_valid}, 13'd0);
    chk("bp_release_ready", {12'd0, bus.in_ready},  13'd1);
    tick();
    bus.in_valid = 1'b0;
    wait_out("bp_new_latency", 1);
    chk("bp_new_d_out", bus.d_out, 13'(-5));
    chk("bp_new_acc",   bus.acc,   13'd1);
    tick();

    // acc_clr coinciding with the SIGN edge: 1 * 8 = 8, not added
    accept(1'b0, 3'd3, 5'd1);
    tick();
    tick();
    tick();
    bus.acc_clr = 1'b1;
    tick();
    bus.acc_clr = 1'b0;
    chk("coclr_out_valid", {12'd0, bus.out_valid}, 13'd1);
    chk("coclr_d_out",     bus.d_out,                13'd8);
    chk("coclr_acc",       bus.acc,                  13'd0);
    chk("coclr_sat",       {12'd0, bus.sat},       13'd0);
    tick();

    // Build up nonzero state, then reset in the middle of a SHIFT
    accept(1'b0, 3'd0, 5'd9);
    wait_out("pre_rst_latency", 1);
    chk("pre_rst_d_out", bus.d_out, 13'd9);
    chk("pre_rst_acc",   bus.acc,   13'd9);
    tick();
    accept(1'b0, 3'd6, 5'd31);
    tick();
    tick();
    #3 rst = 1'b1;
    #1;
    chk("midrst_d_out",     bus.d_out,                13'd0);
    chk("midrst_acc",       bus.acc,                  13'd0);
    chk("midrst_sat",       {12'd0, bus.sat},       13'd0);
    chk("midrst_out_valid", {12'd0, bus.out_valid}, 13'd0);
    chk("midrst_in_ready",  {12'd0, bus.in_ready},  13'd1);
    #2 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("midrst_no_out", 13'(seen), 13'd0);

    // Recovery after reset: -1
    accept(1'b1, 3'd0, 5'd1);
    wait_out("post_rst_latency", 1);
    chk("post_rst_d_out", bus.d_out, 13'(-1));
    chk("post_rst_acc",   bus.acc,   13'(-1));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_expand_acc.md
# fp_expand_acc

Downstream consumer of the FPCVT sign/exponent/significand format. Accepts one (S, E, F) word per valid/ready handshake and expands it back to a 13-bit two's-complement linear value with an iterative one-bit-per-cycle shifter. Keeps a saturating running sum of all expanded values. Used to check round-trip error of the converter and to reconstruct linear amplitudes for later stages.

## Interface

Parameters:
- ACC_W, default 13: accumulator width in bits, signed two's complement; must be ≥ 13.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  s/e/f are valid.
- in_ready  out  1  block can accept a word.
- s  in  1  sign; 1 means negative.
- e  in  3  exponent, 0..7.
- f  in  5  significand, 0..31; no normalisation required.
- acc_clr  in  1  synchronous clear of acc and sat.
- out_valid  out  1  d_out is valid.
- out_ready  in  1  consumer accepts d_out.
- d_out  out  13  expanded value, (−1)^s · f · 2^e, two's complement.
- acc  out  ACC_W  saturating running sum of every d_out produced.
- sat  out  1  sticky flag: acc has saturated since the last clear or reset.

## Operation

- Magnitude range is 0..3968 (31·2^7), so d_out never overflows 13 bits.
- Four-state FSM:
  - IDLE: in_ready=1. When in_valid && in_ready, capture mag ← {8'b0, f}, cnt ← e, sgn ← s. Go to SHIFT if e≠0, otherwise go to SIGN.
  - SHIFT: mag ← mag<<1 and cnt ← cnt−1 each cycle. Go to SIGN when cnt==1.
  - SIGN: d_out ← sgn ? −mag : mag. Update acc. Go to HOLD.
  - HOLD: out_valid=1 and d_out is held stable. When out_ready=1, go to IDLE.
- in_ready is 1 only in IDLE. in_valid is ignored in every other state.
- Zero handling: s=1 with f=0 gives d_out=0, never a negative zero.
- Accumulator update in SIGN:
  - sum = acc + sign-extended d_out.
  - If sum > 2^(ACC_W−1)−1, acc ← max and sat ← 1.
  - If sum < −2^(ACC_W−1), acc ← min and sat ← 1.
  - Otherwise acc ← sum.
- acc_clr sets acc ← 0 and sat ← 0 in any state.
  - If acc_clr coincides with the SIGN cycle, the clear wins and that sample is not added.
  - d_out for that sample is still produced normally.
- Reset (asynchronous, any state, including mid-SHIFT): the FSM goes to IDLE and the in-flight word is discarded.
  - Reset values: d_out=0, acc=0, sat=0, out_valid=0, internal mag/cnt=0.
  - in_ready reads 1, because it is decoded from IDLE.

## Timing

- Accept edge is edge 0, the first rising edge with in_valid && in_ready.
- out_valid rises at edge e+1, i.e. latency is e+1 cycles. e=0 gives 1 cycle; e=7 gives 8 cycles.
- out_valid falls on the edge where out_valid && out_ready is sampled high.
- in_ready rises on that same edge, so the next word can be accepted one cycle later.
- Throughput with no backpressure: one word per e+3 cycles.
- Under backpressure, HOLD persists indefinitely. d_out, acc and sat stay constant and no input is accepted.
- acc and sat change only on the SIGN edge, on an acc_clr edge, or on reset.

## Test plan

- Reset: assert rst asynchronously mid-cycle. Outputs must go to 0 immediately: d_out=0, acc=0, sat=0, out_valid=0. in_ready must read 1.
- Positive: s=0, e=2, f=11011 → out_valid 3 cycles after accept, d_out=13'b0000001101100 (108), acc=108.
- Negative and zero:
  - s=1, e=4, f=11010 → d_out=13'b1111001100000 (−416).
  - Then s=1, e=5, f=0 → d_out=0 and acc unchanged.
- Saturation (ACC_W=13): send s=0, e=7, f=31 twice → each has latency 8 and d_out=3968. After the second word, acc=4095 and sat=1. A following acc_clr → acc=0, sat=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in HOLD and drive in_valid=1 with new data. d_out must stay stable, in_ready must stay 0, and the new word must not be taken.
  - Release out_ready → IDLE, then the new word is accepted.
- Coincident events:
  - Pulse acc_clr exactly in the SIGN cycle → acc=0 and d_out correct.
  - Assert rst during SHIFT of e=6 → FSM in IDLE and out_valid never rises for the aborted word.
